// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register command sequencer:
// op codes, register mux encodings, FSM states and default widths.
package usr_pkg;

  localparam int USR_DATA_WIDTH = 4;
  localparam int USR_CNT_WIDTH  = 3;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4
  } op_e;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ROL;
  endfunction

  // Right-moving ops feed the register's sr input and drop q[0].
  function automatic logic op_is_right(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/usr_sequencer.sv
// Command-driven controller for a 4-bit universal shift register: accepts
// one load/shift/rotate command, steps the register, then returns the word.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH = USR_DATA_WIDTH,
  parameter int CNT_WIDTH  = USR_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  cmd_fill,
  output logic [1:0]            sel_mux,
  output logic                  sr,
  output logic                  sl,
  output logic [DATA_WIDTH-1:0] in,
  input  logic [DATA_WIDTH-1:0] q_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last_out,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready;
  // a response transfers on the edge where rsp_valid && rsp_ready. Once
  // rsp_valid rises, rsp_data/rsp_last_out/rsp_err hold until that transfer.

  state_e                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   in_q, in_d;
  logic                    fill_q, fill_d;
  logic [2:0]              op_q, op_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_HOLD;
      in_q    <= '0;
      fill_q  <= 1'b0;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      in_q    <= in_d;
      fill_q  <= fill_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    in_d    = in_q;
    fill_d  = fill_q;
    op_d    = op_q;
    rem_d   = rem_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        sel_d = SEL_HOLD;
        if (cmd_valid) begin
          op_d   = cmd_op;
          fill_d = cmd_fill;
          in_d   = cmd_data;
          rem_d  = cmd_count;
          last_d = 1'b0;
          err_d  = 1'b0;
          if (!op_legal(cmd_op)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (cmd_op == OP_LOAD) begin
            sel_d   = SEL_LOAD;
            state_d = ST_EXEC;
          end else if (cmd_count == '0) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = op_is_right(cmd_op) ? SEL_SHR : SEL_SHL;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (sel_q == SEL_LOAD) begin
          sel_d   = SEL_HOLD;
          state_d = ST_DONE;
        end else begin
          // The bit leaving the register on this edge is still visible on q_out.
          last_d = op_is_right(op_q) ? q_out[0] : q_out[DATA_WIDTH-1];
          rem_d  = rem_q - 1'b1;
          if (rem_q == CNT_WIDTH'(1)) begin
            sel_d   = SEL_HOLD;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        sel_d = SEL_HOLD;
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sel_d   = SEL_HOLD;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sr = 1'b0;
    sl = 1'b0;
    case (op_q)
      OP_SHR, OP_SHL: begin
        sr = fill_q;
        sl = fill_q;
      end
      OP_ROR:  sr = q_out[0];
      OP_ROL:  sl = q_out[DATA_WIDTH-1];
      default: ;
    endcase
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_DONE);
  assign rsp_data     = rsp_valid ? q_out : '0;
  assign rsp_last_out = last_q;
  assign rsp_err      = err_q;
  assign sel_mux      = sel_q;
  assign in           = in_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer driving a behavioural 4-bit universal shift register;
// responses are checked against a word-level model of each command.
module tb_usr_sequencer;

  localparam int DW = 4;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic          cmd_valid, cmd_ready, cmd_fill;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [CW-1:0] cmd_count;
  logic [1:0]    sel_mux;
  logic          sr, sl;
  logic [DW-1:0] in_w, q_reg;
  logic          rsp_valid, rsp_ready, rsp_last_out, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [1:0]    dbg_state;

  usr_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .sel_mux(sel_mux), .sr(sr), .sl(sl), .in(in_w), .q_out(q_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last_out(rsp_last_out), .rsp_err(rsp_err), .dbg_state_o(dbg_state)
  );

  // Universal shift register the sequencer controls (not cleared by clr).
  always @(posedge clk) begin
    case (sel_mux)
      2'b01:   q_reg <= {sr, q_reg[DW-1:1]};
      2'b10:   q_reg <= {q_reg[DW-2:0], sl};
      2'b11:   q_reg <= in_w;
      default: q_reg <= q_reg;
    endcase
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_mis = 0;
  logic [DW-1:0] exp_q[$];
  int            model_word = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: result, last bit out, error, latency, active cycles, mux code.
  task automatic model_cmd(input int op, input int data, input int count, input int fill,
                           output int w, output int last, output int err,
                           output int lat, output int busy, output int sel);
    w = model_word; last = 0; err = 0; sel = 0; busy = 0;
    if (op > 4) begin
      err = 1; lat = 1;
    end else if (op == 0) begin
      w = data; lat = 2; busy = 1; sel = 3;
    end else if (count == 0) begin
      lat = 1;
    end else begin
      lat = count + 1; busy = count;
      sel = (op == 1 || op == 3) ? 1 : 2;
      for (int i = 0; i < count; i++) begin
        case (op)
          1: begin last = w & 1;        w = (w >> 1) | (fill << 3); end
          2: begin last = (w >> 3) & 1; w = ((w << 1) | fill) & 15; end
          3: begin last = w & 1;        w = (w >> 1) | ((w & 1) << 3); end
          default: begin last = (w >> 3) & 1; w = ((w << 1) | (w >> 3)) & 15; end
        endcase
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called and returns at a negedge with the DUT idle.
  task automatic do_cmd(input int op, input int data, input int count, input int fill, input int hold);
    int w, e_last, e_err, e_lat, e_busy, e_sel;
    int lat, busy, bad;
    logic [DW-1:0] exp_word;
    model_cmd(op, data, count, fill, w, e_last, e_err, e_lat, e_busy, e_sel);
    exp_q.push_back(DW'(w));
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = DW'(data);
    cmd_count = CW'(count);
    cmd_fill  = fill[0];
    @(posedge clk); @(negedge clk);
    // Keep offering unrelated commands; they must be ignored while busy.
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_data  = DW'($urandom);
    cmd_count = CW'($urandom);
    lat = 0; busy = 0; bad = 0;
    while (1) begin
      lat++;
      if (sel_mux == 2'(e_sel) && e_sel != 0) busy++;
      else if (sel_mux != 2'b00) bad++;
      if (rsp_valid || lat > 20) break;
      @(posedge clk); @(negedge clk);
    end
    exp_word = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("latency", lat, e_lat);
    check("mux_active_cycles", busy, e_busy);
    check("mux_wrong_code", bad, 0);
    check("rsp_data", rsp_data, exp_word);
    check("rsp_last_out", rsp_last_out, e_last);
    check("rsp_err", rsp_err, e_err);
    check("done_ready", cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp_word);
      check("hold_err", rsp_err, e_err);
      check("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", rsp_valid, 0);
    check("post_ready", cmd_ready, 1);
    check("post_err", rsp_err, 0);
    model_word = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, e_last, e_err, e_lat, e_busy, e_sel;
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    cmd_fill = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_sel", sel_mux, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_last", rsp_last_out, 0);
    check("rst_in", in_w, 0);
    check("rst_state", dbg_state, usr_pkg::ST_IDLE);
    clr = 1'b0;

    do_cmd(0, 4'b1011, 0, 0, 0);   // LOAD
    do_cmd(1, 0, 2, 0, 0);         // SHR 2 -> 0010
    do_cmd(0, 4'b1011, 0, 0, 0);
    do_cmd(4, 0, 1, 0, 0);         // ROL 1 -> 0111
    do_cmd(0, 4'b0010, 0, 0, 0);
    do_cmd(3, 0, 4, 0, 0);         // ROR 4 -> unchanged
    do_cmd(2, 0, 0, 1, 0);         // SHL count 0
    do_cmd(6, 0, 3, 0, 0);         // illegal op
    do_cmd(1, 0, 1, 1, 3);         // response held off for 3 cycles
    do_cmd(2, 0, 7, 1, 1);         // max count

    // Reset in the second cycle of a 5-step shift: only two steps happen.
    check("mid_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_count = 3'd5; cmd_fill = 1'b1; cmd_data = '0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_sel", sel_mux, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_err", rsp_err, 0);
    check("mid_rst_state", dbg_state, usr_pkg::ST_IDLE);
    model_cmd(1, 0, 2, 1, w, e_last, e_err, e_lat, e_busy, e_sel);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_word", q_reg, w);
    model_word = w;

    for (int n = 0; n < 40; n++) begin
      do_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
